// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int          XLEN      = 64;
    localparam int          INSTR_W   = 32;
    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_stage_buffer.sv
// Small circular FIFO holding fetched {pc, instruction} pairs for the decode stage.
// Flush empties the queue and takes priority over a simultaneous push.
module if_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  if_entry_t        push_entry,
    output if_entry_t        head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    if_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage carries no reset; the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues PCs to a 1-cycle instruction memory and hands
// {pc, instruction, pc_next} to decode. Optional counters under IF_PERF_CNT_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int          XLEN      = if_pkg::XLEN,
    parameter logic [63:0] RESET_PC  = if_pkg::RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc_next
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  tag_reg;
    logic             inflight_reg;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic [XLEN-1:0]  redirect_aligned;
    logic             pop;
    logic             push;
    if_entry_t        head;
    if_entry_t        push_entry;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign if_valid         = (count != '0);
    assign pop              = if_valid && id_ready;

    // Entries already buffered or in flight, less the one leaving this cycle.
    assign occupancy = {1'b0, count} + OCC_W'(inflight_reg) - OCC_W'(pop);
    assign imem_req  = rst_n && !redirect_valid && (occupancy < OCC_W'(BUF_DEPTH));
    assign imem_addr = pc_reg;

    // A redirect kills the response arriving this cycle.
    assign push             = inflight_reg && !redirect_valid;
    assign push_entry.pc    = tag_reg;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= XLEN'(RESET_PC);
            tag_reg      <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) tag_reg <= pc_reg;
            if (redirect_valid) begin
                pc_reg <= redirect_aligned;
            end else if (imem_req) begin
                pc_reg <= pc_reg + XLEN'(4);
            end
        end
    end

    if_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    // Outputs read as zero whenever nothing valid is presented, including in reset.
    assign if_pc          = if_valid ? head.pc : '0;
    assign if_instruction = if_valid ? head.instr : '0;
    assign if_pc_next     = if_valid ? head.pc + XLEN'(4) : '0;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (id_ready && !if_valid && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for streaming/stall/redirect,
// plus hand-written async-reset, PC-wrap and (under IF_PERF_CNT_EN) counter checks.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic [63:0] if_pc_next;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .XLEN      (64),
        .RESET_PC  (64'h1000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_pc_next     (if_pc_next)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return addr[31:0] ^ 32'h5A5A_0013;
    endfunction

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        req;
        logic [63:0] addr;
        logic        v;
        logic [63:0] pc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] rpc,
                                input logic req, input logic [63:0] addr,
                                input logic v, input logic [63:0] pc);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc;
        r.req = req; r.addr = addr; r.v = v; r.pc = pc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic req, input logic [63:0] addr,
                                 input logic v, input logic [63:0] pc);
        logic [31:0] exp_instr;
        logic [63:0] exp_next;
        exp_instr = v ? mem_word(pc) : 32'h0;
        exp_next  = v ? pc + 64'd4 : 64'h0;
        check({tag, " imem_req"}, {63'h0, imem_req}, {63'h0, req});
        if (req) check({tag, " imem_addr"}, imem_addr, addr);
        check({tag, " if_valid"}, {63'h0, if_valid}, {63'h0, v});
        check({tag, " if_pc"}, if_pc, v ? pc : 64'h0);
        check({tag, " if_instruction"}, {32'h0, if_instruction}, {32'h0, exp_instr});
        check({tag, " if_pc_next"}, if_pc_next, exp_next);
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
        @(negedge clk);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Stream, 5-cycle stall, redirect to 2003 while occupancy is full, then 3000->4000.
        vecs[0]  = mk(1, 0, 64'h0,    1, 64'h1000, 0, 64'h0);
        vecs[1]  = mk(1, 0, 64'h0,    1, 64'h1004, 0, 64'h0);
        vecs[2]  = mk(1, 0, 64'h0,    1, 64'h1008, 1, 64'h1000);
        vecs[3]  = mk(1, 0, 64'h0,    1, 64'h100C, 1, 64'h1004);
        vecs[4]  = mk(0, 0, 64'h0,    0, 64'h1010, 1, 64'h1008);
        vecs[5]  = mk(0, 0, 64'h0,    0, 64'h1010, 1, 64'h1008);
        vecs[6]  = mk(0, 0, 64'h0,    0, 64'h1010, 1, 64'h1008);
        vecs[7]  = mk(0, 0, 64'h0,    0, 64'h1010, 1, 64'h1008);
        vecs[8]  = mk(0, 0, 64'h0,    0, 64'h1010, 1, 64'h1008);
        vecs[9]  = mk(1, 0, 64'h0,    1, 64'h1010, 1, 64'h1008);
        vecs[10] = mk(1, 0, 64'h0,    1, 64'h1014, 1, 64'h100C);
        vecs[11] = mk(1, 0, 64'h0,    1, 64'h1018, 1, 64'h1010);
        vecs[12] = mk(0, 1, 64'h2003, 0, 64'h101C, 1, 64'h1014);
        vecs[13] = mk(1, 0, 64'h0,    1, 64'h2000, 0, 64'h0);
        vecs[14] = mk(1, 0, 64'h0,    1, 64'h2004, 0, 64'h0);
        vecs[15] = mk(1, 0, 64'h0,    1, 64'h2008, 1, 64'h2000);
        vecs[16] = mk(1, 0, 64'h0,    1, 64'h200C, 1, 64'h2004);
        vecs[17] = mk(1, 1, 64'h3000, 0, 64'h2010, 1, 64'h2008);
        vecs[18] = mk(1, 1, 64'h4000, 0, 64'h3000, 0, 64'h0);
        vecs[19] = mk(1, 0, 64'h0,    1, 64'h4000, 0, 64'h0);
        vecs[20] = mk(1, 0, 64'h0,    1, 64'h4004, 0, 64'h0);
        vecs[21] = mk(1, 0, 64'h0,    1, 64'h4008, 1, 64'h4000);
        vecs[22] = mk(1, 0, 64'h0,    1, 64'h400C, 1, 64'h4004);

        // Reset state while rst_n is low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset imem_req", {63'h0, imem_req}, 64'h0);
        check("reset if_valid", {63'h0, if_valid}, 64'h0);
        check("reset if_pc", if_pc, 64'h0);
        check("reset if_instruction", {32'h0, if_instruction}, 64'h0);
        check("reset if_pc_next", if_pc_next, 64'h0);

        id_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            $display("vec %0d: rdy=%0b redir=%0b req=%0b addr=%h valid=%0b pc=%h", i,
                     id_ready, redirect_valid, imem_req, imem_addr, if_valid, if_pc);
            check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].pc);
        end

        // Async reset mid-stream with a request in flight: outputs drop without a clock edge.
        @(negedge clk);
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        $display("async reset: req=%0b valid=%0b pc=%h", imem_req, if_valid, if_pc);
        check_outputs("async_rst", 1'b0, 64'h0, 1'b0, 64'h0);
        release_reset();
        step(1, 0, 64'h0);
        check_outputs("post_rst c0", 1'b1, 64'h1000, 1'b0, 64'h0);
        step(1, 0, 64'h0);
        check_outputs("post_rst c1", 1'b1, 64'h1004, 1'b0, 64'h0);
        step(1, 0, 64'h0);
        check_outputs("post_rst c2", 1'b1, 64'h1008, 1'b1, 64'h1000);

        // PC wraps modulo 2^64.
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        check_outputs("wrap redir", 1'b0, 64'h0, 1'b1, 64'h1004);
        step(1, 0, 64'h0);
        check_outputs("wrap c1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
        step(1, 0, 64'h0);
        check_outputs("wrap c2", 1'b1, 64'h0, 1'b0, 64'h0);
        step(1, 0, 64'h0);
        $display("wrap: addr=%h pc=%h pc_next=%h", imem_addr, if_pc, if_pc_next);
        check_outputs("wrap c3", 1'b1, 64'h4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef IF_PERF_CNT_EN
        // 2 startup bubbles, 10 pops, a redirect with id_ready low, then 1 more bubble.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("perf reset fetch", {32'h0, perf_fetch_cnt}, 64'h0);
        release_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 64'h0);
        step(0, 1, 64'h8000);
        step(1, 0, 64'h0);
        step(0, 0, 64'h0);
        step(0, 0, 64'h0);
        $display("perf: fetch=%0d bubble=%0d", perf_fetch_cnt, perf_bubble_cnt);
        check("perf_fetch_cnt", {32'h0, perf_fetch_cnt}, 64'd10);
        check("perf_bubble_cnt", {32'h0, perf_bubble_cnt}, 64'd3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
